// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the program-loader path:
//                loader state encoding, instruction word width and the
//                number of byte lanes per word.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;
    localparam int LANE_CNT_W = $clog2(BYTE_LANES);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_if
//  Description : Bundle for the program loader: UART byte stream (valid/ready),
//                reload request, instruction RAM write port and status.
//                master  - the loader itself
//                slave   - the surrounding system (UART, RAM, core)
//  Signals     : rx_valid/rx_data/rx_ready  byte stream handshake
//                reload                     restart request while done
//                wr_en_instr/addr_in_instr/data_in_instr  RAM write port
//                loading/done/overflow/core_rstn          status
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        wr_en_instr;
    logic [31:0] addr_in_instr;
    logic [31:0] data_in_instr;
    logic        loading;
    logic        done;
    logic        overflow;
    logic        core_rstn;

    modport master (
        input  rx_valid, rx_data, reload,
        output rx_ready, wr_en_instr, addr_in_instr, data_in_instr,
               loading, done, overflow, core_rstn
    );

    modport slave (
        output rx_valid, rx_data, reload,
        input  rx_ready, wr_en_instr, addr_in_instr, data_in_instr,
               loading, done, overflow, core_rstn
    );

endinterface : instr_loader_if
`default_nettype wire

// File: rtl/instr_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : byte_assembler
//  Description : Packs accepted bytes into little-endian 32-bit words.
//                Byte 0 of a word ends up in [7:0]. word_valid_o pulses in
//                the cycle the 4th byte is accepted, with word_o already
//                holding the complete word (incoming byte included).
//  Ports       : clk, rstn      clock, synchronous active-low reset
//                clr_i          restart lane counting at lane 0
//                accept_i       a byte is transferred this cycle
//                byte_i         the byte being transferred
//                word_o         assembled word (valid with word_valid_o)
//                word_valid_o   4th byte of a word accepted this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module byte_assembler
    import cpu_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rstn,
    input  wire logic              clr_i,
    input  wire logic              accept_i,
    input  wire logic [7:0]        byte_i,
    output logic      [WORD_W-1:0] word_o,
    output logic                   word_valid_o
);

    logic [LANE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]     shreg_q,    shreg_d;

    // Shifting in from the top means after four bytes the first one sits in
    // [7:0]; the next-state value is therefore the finished word.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        if (clr_i) begin
            byte_cnt_d = '0;
        end else if (accept_i) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            shreg_d    = {byte_i, shreg_q[WORD_W-1:8]};
        end
    end

    assign word_o       = shreg_d;
    assign word_valid_o = accept_i && !clr_i &&
                          (byte_cnt_q == LANE_CNT_W'(BYTE_LANES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt_q <= '0;
            shreg_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

endmodule : byte_assembler
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Program loader. Receives a 4-byte little-endian word count N
//                followed by N little-endian words from the UART, writes them
//                to consecutive instruction RAM word addresses and keeps the
//                core in reset until the image is complete.
//  Parameters  : DEPTH     words in instruction RAM
//                LOGDEPTH  log2(DEPTH)
//  Ports       : clk, rstn  clock, synchronous active-low reset
//                bus        instr_loader_if.master (stream, RAM port, status)
//  Revision    : 1.0  initial release
// ============================================================================
module instr_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int LOGDEPTH = 5
) (
    input  wire logic     clk,
    input  wire logic     rstn,
    instr_loader_if.master bus
);

    ld_state_t         state_q,    state_d;
    logic [WORD_W-1:0] word_idx_q, word_idx_d;
    logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
    logic              overflow_q, overflow_d;
    logic              pend_q,     pend_d;
    logic              wr_en_q,    wr_en_d;
    logic [WORD_W-1:0] addr_q,     addr_d;
    logic [WORD_W-1:0] data_q,     data_d;

    logic              rx_ready;
    logic              accept;
    logic              asm_clr;
    logic [WORD_W-1:0] asm_word;
    logic              asm_valid;
    logic [WORD_W-1:0] word_idx_inc;
    logic              idx_in_range;

    assign accept       = bus.rx_valid && rx_ready;
    assign word_idx_inc = word_idx_q + 1'b1;
    // DEPTH is a power of two, so "index < DEPTH" is "no bits above LOGDEPTH".
    assign idx_in_range = (word_idx_q[WORD_W-1:LOGDEPTH] == '0);

    byte_assembler u_asm (
        .clk          (clk),
        .rstn         (rstn),
        .clr_i        (asm_clr),
        .accept_i     (accept),
        .byte_i       (bus.rx_data),
        .word_o       (asm_word),
        .word_valid_o (asm_valid)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        word_cnt_d = word_cnt_q;
        overflow_d = overflow_q;
        pend_d     = 1'b0;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        rx_ready   = 1'b0;
        asm_clr    = 1'b0;

        case (state_q)
            ST_HDR: begin
                rx_ready = 1'b1;
                if (asm_valid) begin
                    word_cnt_d = asm_word;
                    word_idx_d = '0;
                    if (asm_word > WORD_W'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end
                    state_d = (asm_word == '0) ? ST_DONE : ST_DATA;
                end
            end

            ST_DATA: begin
                // One-bubble write: no byte is taken while the strobe is out.
                rx_ready = !wr_en_q;

                // pend_q marks the cycle after a word completed (written or
                // discarded); the index advances there and completion is
                // detected as it reaches the header count.
                if (pend_q) begin
                    word_idx_d = word_idx_inc;
                    if (word_idx_inc == word_cnt_q) begin
                        state_d = ST_DONE;
                    end
                end

                if (asm_valid) begin
                    pend_d  = 1'b1;
                    wr_en_d = idx_in_range;
                    if (idx_in_range) begin
                        data_d = asm_word;
                        addr_d = {word_idx_q[WORD_W-3:0], 2'b00};
                    end
                end
            end

            ST_DONE: begin
                if (bus.reload) begin
                    asm_clr    = 1'b1;
                    word_idx_d = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_HDR;
                end
            end

            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_HDR;
            word_idx_q <= '0;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
            pend_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
            pend_q     <= pend_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.rx_ready      = rx_ready;
    assign bus.wr_en_instr   = wr_en_q;
    assign bus.addr_in_instr = addr_q;
    assign bus.data_in_instr = data_q;
    assign bus.done          = (state_q == ST_DONE);
    assign bus.core_rstn     = (state_q == ST_DONE);
    assign bus.loading       = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign bus.overflow      = overflow_q;

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader. Images are built from
//                the loader's byte-stream format; a write scoreboard holds the
//                (address, word) pairs each image must produce.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_loader;

    localparam int DEPTH = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    instr_loader_if bus ();

    instr_loader #(.DEPTH(DEPTH), .LOGDEPTH(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    wr_t         exp_q[$];
    logic [7:0]  img_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: stream format -> expected writes ----
    task automatic add_header(input logic [31:0] n);
        for (int k = 0; k < 4; k++) img_q.push_back(n[8*k +: 8]);
    endtask

    task automatic add_word(input int idx, input logic [31:0] w);
        wr_t e;
        for (int k = 0; k < 4; k++) img_q.push_back(w[8*k +: 8]);
        if (idx < DEPTH) begin
            e.addr = 32'(idx * 4);
            e.data = w;
            exp_q.push_back(e);
        end
    endtask

    // ---------------- write monitor / scoreboard ---------------------------
    always @(negedge clk) begin
        if (rstn && bus.wr_en_instr) begin
            wr_t e;
            n_writes++;
            check_eq("wr_rx_ready_low", bus.rx_ready, 0);
            check_eq("wr_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("wr_addr", bus.addr_in_instr, e.addr);
                check_eq("wr_data", bus.data_in_instr, e.data);
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    // Returns #1 after the clock edge on which the byte was taken.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit acc;
        int guard = 0;
        @(negedge clk);
        if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        acc = bus.rx_ready;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = bus.rx_ready;
            guard++;
        end
        if (!acc) check_eq("accept_timeout", acc, 1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input int cnt, input bit rnd);
        for (int i = 0; i < cnt && img_q.size() != 0; i++) begin
            send_byte(img_q.pop_front(), rnd);
        end
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        @(negedge clk);
        while (!bus.done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_reached", bus.done, 1);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_done",      bus.done,          0);
        check_eq("rst_core_rstn", bus.core_rstn,     0);
        check_eq("rst_loading",   bus.loading,       1);
        check_eq("rst_wr_en",     bus.wr_en_instr,   0);
        check_eq("rst_addr",      bus.addr_in_instr, 0);
        check_eq("rst_data",      bus.data_in_instr, 0);
        check_eq("rst_overflow",  bus.overflow,      0);
        check_eq("rst_rx_ready",  bus.rx_ready,      1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] w[3];
        int          wr_base;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.reload   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rstn = 1'b1;

        // --- two-word image, back-to-back bytes, exact write/done timing ---
        add_header(32'd2);
        add_word(0, 32'h00100093);
        add_word(1, 32'h00100113);
        send_bytes(img_q.size(), 1'b0);
        @(negedge clk);
        check_eq("a_last_wr_strobe", bus.wr_en_instr, 1);
        check_eq("a_done_early",     bus.done,        0);
        @(negedge clk);
        check_eq("a_done",      bus.done,      1);
        check_eq("a_core_rstn", bus.core_rstn, 1);
        check_eq("a_loading",   bus.loading,   0);
        check_eq("a_rx_ready",  bus.rx_ready,  0);
        check_eq("a_exp_empty", exp_q.size(),  0);

        // --- empty image: done the cycle after the 4th header byte ---------
        pulse_reload();
        check_eq("b_done_dropped", bus.done, 0);
        add_header(32'd0);
        send_bytes(img_q.size(), 1'b0);
        @(negedge clk);
        check_eq("b_done",    bus.done,    1);
        check_eq("b_loading", bus.loading, 0);

        // --- three random words, rx_valid toggling randomly ----------------
        pulse_reload();
        add_header(32'd3);
        for (int i = 0; i < 3; i++) add_word(i, $urandom);
        send_bytes(img_q.size(), 1'b1);
        wait_done(20);
        check_eq("c_exp_empty", exp_q.size(), 0);

        // --- N=34 > DEPTH: last two words consumed without writes ----------
        pulse_reload();
        wr_base = n_writes;
        add_header(32'd34);
        for (int i = 0; i < 34; i++) add_word(i, $urandom);
        send_bytes(img_q.size(), ($urandom_range(0, 1) == 1));
        wait_done(20);
        check_eq("d_overflow",    bus.overflow,       1);
        check_eq("d_write_count", n_writes - wr_base, 32);
        check_eq("d_exp_empty",   exp_q.size(),       0);

        // --- reset after 6 bytes, then the full image again ----------------
        pulse_reload();
        check_eq("e_overflow_cleared", bus.overflow, 0);
        w[0] = $urandom;
        w[1] = $urandom;
        add_header(32'd2);
        add_word(0, w[0]);
        add_word(1, w[1]);
        send_bytes(6, 1'b0);
        img_q.delete();
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rstn = 1'b1;
        add_header(32'd2);
        add_word(0, w[0]);
        add_word(1, w[1]);
        send_bytes(img_q.size(), 1'b1);
        wait_done(20);
        check_eq("e_exp_empty", exp_q.size(), 0);

        // --- reload then one word; a reload mid-header must be ignored -----
        pulse_reload();
        check_eq("f_done_dropped",      bus.done,      0);
        check_eq("f_core_rstn_dropped", bus.core_rstn, 0);
        add_header(32'd1);
        add_word(0, 32'hDEADBEEF);
        send_bytes(2, 1'b0);
        pulse_reload();
        check_eq("f_still_loading", bus.loading, 1);
        send_bytes(img_q.size(), 1'b0);
        wait_done(20);
        check_eq("f_exp_empty",  exp_q.size(), 0);
        check_eq("f_core_rstn",  bus.core_rstn, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_loader
`default_nettype wire
